// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package mem_arb_pkg;

   // Owner tag stored per outstanding read; selects which requester gets the response.
   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

   // Arbitration result for the current cycle.
   typedef enum logic {
      WIN_I = 1'b0,
      WIN_D = 1'b1
   } winner_e;

   // Occupancy counter must represent 0..max_outst inclusive.
   function automatic int cnt_width(input int max_outst);
      return $clog2(max_outst) + 1;
   endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// 1-bit owner-tag FIFO tracking reads in flight to memory, oldest at the head.
// Latency: push visible at head one cycle after write into an empty FIFO; head/empty/full are registered-state based.
// Backpressure: push ignored when full, pop ignored when empty; a same-cycle pop does not make room for a push when full.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears contents and pointers)
//   push, push_tag      enqueue one owner tag
//   pop                 dequeue the head tag
//   head_tag            tag at the head (valid when !empty)
//   empty, full, count  occupancy status; count ranges 0..DEPTH
module mem_arb_tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic                        push_tag,
   input  logic                        pop,
   output logic                        head_tag,
   output logic                        empty,
   output logic                        full,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [DEPTH-1:0] tags;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Status comes from the counter, so pointers can wrap freely (DEPTH is a power of 2).
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign head_tag = tags[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            tags[wr_ptr] <= push_tag;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I, read-only) and data access (D).
// Latency: request-to-grant is combinational; mem_rvalid-to-x_rvalid is combinational; responses return in order.
// Backpressure: loser sees gnt=0 and holds; all requests blocked while MAX_OUTST reads are in flight.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt               fetch request side; i_rvalid/i_rdata fetch response
//   d_req/d_we/d_addr/d_wdata -> d_gnt  data request side; d_rvalid/d_rdata data response
//   mem_req/mem_we/mem_addr/mem_wdata   request to memory, accepted when mem_gnt
//   mem_rvalid/mem_rdata                in-order read response from memory
//   outst_cnt                           reads in flight
//   err                                 sticky: response arrived with nothing outstanding
//
// Build option: define MEM_PORT_ARBITER_STARVE_GUARD_EN to let I override D after
// STARVE_LIMIT consecutive D wins while I is waiting. Default build is strict D priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int MAX_OUTST    = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_req,
   input  logic [AW-1:0]                   i_addr,
   output logic                            i_gnt,
   output logic                            i_rvalid,
   output logic [DW-1:0]                   i_rdata,
   input  logic                            d_req,
   input  logic                            d_we,
   input  logic [AW-1:0]                   d_addr,
   input  logic [DW-1:0]                   d_wdata,
   output logic                            d_gnt,
   output logic                            d_rvalid,
   output logic [DW-1:0]                   d_rdata,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic [AW-1:0]                   mem_addr,
   output logic [DW-1:0]                   mem_wdata,
   input  logic                            mem_gnt,
   input  logic                            mem_rvalid,
   input  logic [DW-1:0]                   mem_rdata,
   output logic [cnt_width(MAX_OUTST)-1:0] outst_cnt,
   output logic                            err
);

   winner_e winner;
   logic    win_d;
   logic    fifo_full;
   logic    fifo_empty;
   logic    head_tag;
   logic    accept;
   logic    push;
   logic    push_tag;
   logic    pop;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt;
   logic          starve_force;

   assign starve_force = (int'(starve_cnt) >= STARVE_LIMIT);

   // Counts D wins that happened while I was waiting; any I grant or I dropping its
   // request clears it. Saturates so it never wraps back below the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!i_req || i_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && !starve_force) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

   // D has priority; the starvation guard (when built) hands the slot to a waiting I.
   always_comb begin
      winner = WIN_I;
      if (d_req) begin
         winner = WIN_D;
      end
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
      if (i_req && starve_force) begin
         winner = WIN_I;
      end
`endif
   end

   assign win_d = (winner == WIN_D);

   // Full blocks writes too, keeping the request path independent of the op type.
   // rst_n gating keeps every handshake output low during reset.
   assign mem_req   = rst_n & (i_req | d_req) & ~fifo_full;
   assign mem_we    = win_d & d_we;
   assign mem_addr  = win_d ? d_addr : i_addr;
   assign mem_wdata = win_d ? d_wdata : '0;

   assign accept = mem_req & mem_gnt;
   assign i_gnt  = accept & ~win_d;
   assign d_gnt  = accept & win_d;

   // Only reads produce a response, so only reads take a FIFO slot.
   assign push     = accept & ~mem_we;
   assign push_tag = win_d ? OWNER_D : OWNER_I;

   assign pop      = rst_n & mem_rvalid & ~fifo_empty;
   assign i_rvalid = pop & (head_tag == OWNER_I);
   assign d_rvalid = pop & (head_tag == OWNER_D);
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

   // A response with nothing tracked (including one that was in flight across a reset)
   // is dropped and flagged until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (mem_rvalid && fifo_empty) begin
         err <= 1'b1;
      end
   end

   mem_arb_tag_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_tag_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_tag (push_tag),
      .pop      (pop),
      .head_tag (head_tag),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (outst_cnt)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW           = 32;
   localparam int DW           = 32;
   localparam int MAX_OUTST    = 4;
   localparam int STARVE_LIMIT = 3;
   localparam int CW           = $clog2(MAX_OUTST) + 1;
   localparam int NV           = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [CW-1:0] outst_cnt;
   logic          err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW (AW), .DW (DW), .MAX_OUTST (MAX_OUTST), .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt), .i_rvalid (i_rvalid), .i_rdata (i_rdata),
      .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
      .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
      .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
      .outst_cnt (outst_cnt), .err (err)
   );

   typedef struct { int due; logic [DW-1:0] data; } mem_rsp_t;
   typedef struct { logic owner; logic [DW-1:0] data; } exp_rsp_t;
   typedef struct {
      logic ir, dr, we, g;
      logic [AW-1:0] ia, da;
      logic eig, edg, erq, ewe;
      logic [AW-1:0] ea;
   } vec_t;

   mem_rsp_t      pend[$];
   exp_rsp_t      expq[$];
   logic          rv_log[$];
   logic [DW-1:0] mem_arr [0:255];
   vec_t          vec [NV];

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            scnt    = 0;
   int            n_irv   = 0;
   int            n_drv   = 0;
   int            peak    = 0;
   logic          m_err   = 1'b0;
   logic          hold    = 1'b0;
   logic          orphan_req = 1'b0;
   logic          m_igrant = 1'b0;
   logic [DW-1:0] last_drdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mkv(input logic ir, input logic dr, input logic we, input logic g,
                                input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                input logic eig, input logic edg, input logic erq, input logic ewe,
                                input logic [AW-1:0] ea);
      vec_t v;
      v.ir = ir; v.dr = dr; v.we = we; v.g = g; v.ia = ia; v.da = da;
      v.eig = eig; v.edg = edg; v.erq = erq; v.ewe = ewe; v.ea = ea;
      return v;
   endfunction

   // Reference model of the arbiter plus the memory environment, evaluated on settled
   // pre-edge values once per cycle.
   task automatic observe();
      logic          win_d;
      logic          m_req;
      logic          acc;
      logic          exp_irv;
      logic          exp_drv;
      logic [AW-1:0] a;
      exp_rsp_t      e;
      m_igrant = 1'b0;
      if (!rst_n) begin
         expq.delete();
         m_err = 1'b0;
         scnt  = 0;
         chk("rst_i_gnt", i_gnt, 0);
         chk("rst_d_gnt", d_gnt, 0);
         chk("rst_mem_req", mem_req, 0);
         chk("rst_i_rvalid", i_rvalid, 0);
         chk("rst_d_rvalid", d_rvalid, 0);
         chk("rst_outst_cnt", outst_cnt, 0);
         chk("rst_err", err, 0);
         return;
      end
      win_d = d_req;
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
      if (i_req && scnt >= STARVE_LIMIT) win_d = 1'b0;
`endif
      m_req = (i_req | d_req) && (expq.size() < MAX_OUTST);
      acc   = m_req & mem_gnt;
      chk("mem_req", mem_req, m_req);
      chk("i_gnt", i_gnt, acc & ~win_d);
      chk("d_gnt", d_gnt, acc & win_d);
      chk("outst_cnt", outst_cnt, expq.size());
      chk("err", err, m_err);
      if (m_req) chk("mem_we", mem_we, win_d & d_we);
      exp_irv = 1'b0;
      exp_drv = 1'b0;
      if (mem_rvalid) begin
         if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.owner == OWNER_D) begin
               exp_drv = 1'b1;
               chk("d_rdata", d_rdata, e.data);
            end else begin
               exp_irv = 1'b1;
               chk("i_rdata", i_rdata, e.data);
            end
         end else begin
            m_err = 1'b1;
         end
      end
      chk("i_rvalid", i_rvalid, exp_irv);
      chk("d_rvalid", d_rvalid, exp_drv);
      if (i_rvalid) begin n_irv++; rv_log.push_back(OWNER_I); end
      if (d_rvalid) begin n_drv++; rv_log.push_back(OWNER_D); last_drdata = d_rdata; end
      if (int'(outst_cnt) > peak) peak = int'(outst_cnt);
      if (acc && !(win_d && d_we)) begin
         a = win_d ? d_addr : i_addr;
         expq.push_back('{win_d ? OWNER_D : OWNER_I, mem_arr[a[9:2]]});
      end
      m_igrant = acc & ~win_d;
      if (!i_req)               scnt = 0;
      else if (acc && !win_d)   scnt = 0;
      else if (acc && win_d && scnt < STARVE_LIMIT) scnt++;
      // memory environment reacts to what the DUT actually presents
      if (mem_req && mem_gnt) begin
         a = mem_addr;
         if (mem_we) mem_arr[a[9:2]] = mem_wdata;
         else        pend.push_back('{cyc + 2, mem_arr[a[9:2]]});
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      mem_rsp_t p;
      #1;
      observe();
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (orphan_req) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hBAD0_BAD0;
         orphan_req = 1'b0;
      end else if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = p.data;
      end
   endtask

   task automatic drain(input int n);
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      int base;
      logic [7:0] pat;
      logic [7:0] exp_pat;

      for (int k = 0; k < 256; k++) mem_arr[k] = 32'hC0DE_0000 ^ (k * 32'h0101);

      // reset state, with requests and a stray response present
      rst_n = 1'b0; i_req = 1'b1; i_addr = '0; d_req = 1'b1; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
      settle();
      chk("reset_outst_cnt", outst_cnt, 0);
      chk("reset_err", err, 0);
      chk("reset_mem_req", mem_req, 0);
      chk("reset_d_gnt", d_gnt, 0);
      tick(); tick();
      i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
      tick();

      // table-driven arbitration vectors
      vec[0] = mkv(0,0,0,1, 'h40, 'h300, 0,0,0,0, 'h0);
      vec[1] = mkv(1,0,0,1, 'h44, 'h304, 1,0,1,0, 'h44);
      vec[2] = mkv(1,0,0,0, 'h48, 'h308, 0,0,1,0, 'h48);
      vec[3] = mkv(1,0,0,1, 'h48, 'h308, 1,0,1,0, 'h48);
      vec[4] = mkv(0,1,0,1, 'h4c, 'h30c, 0,1,1,0, 'h30c);
      vec[5] = mkv(0,1,1,1, 'h50, 'h310, 0,1,1,1, 'h310);
      vec[6] = mkv(1,1,0,1, 'h54, 'h314, 0,1,1,0, 'h314);
      vec[7] = mkv(1,1,1,0, 'h54, 'h318, 0,0,1,1, 'h318);
      vec[8] = mkv(1,1,1,1, 'h54, 'h318, 0,1,1,1, 'h318);
      vec[9] = mkv(1,0,0,1, 'h54, 'h320, 1,0,1,0, 'h54);
      for (int r = 0; r < NV; r++) begin
         i_req = vec[r].ir; d_req = vec[r].dr; d_we = vec[r].we; mem_gnt = vec[r].g;
         i_addr = vec[r].ia; d_addr = vec[r].da; d_wdata = 32'hA500_0000 | r;
         settle();
         chk($sformatf("vec%0d_i_gnt", r), i_gnt, vec[r].eig);
         chk($sformatf("vec%0d_d_gnt", r), d_gnt, vec[r].edg);
         chk($sformatf("vec%0d_mem_req", r), mem_req, vec[r].erq);
         chk($sformatf("vec%0d_mem_we", r), mem_we, vec[r].ewe);
         if (vec[r].erq) chk($sformatf("vec%0d_mem_addr", r), mem_addr, vec[r].ea);
         tick();
      end
      mem_gnt = 1'b1;
      drain(6);

      // I-only stream of three reads
      base = n_irv; peak = 0;
      i_req = 1'b1; i_addr = 32'h00; settle(); chk("seq1_gnt0", i_gnt, 1); tick();
      i_addr = 32'h04; settle(); chk("seq1_gnt1", i_gnt, 1); tick();
      i_addr = 32'h08; settle(); chk("seq1_gnt2", i_gnt, 1); tick();
      drain(6);
      chk("seq1_i_rvalid_count", n_irv - base, 3);
      chk("seq1_peak_outst", peak, 2);

      // simultaneous I and D read: D first, responses in grant order
      rv_log.delete();
      i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      settle(); chk("seq2_d_gnt", d_gnt, 1); chk("seq2_i_lose", i_gnt, 0); tick();
      d_req = 1'b0;
      settle(); chk("seq2_i_gnt", i_gnt, 1); tick();
      drain(6);
      chk("seq2_rsp_count", rv_log.size(), 2);
      chk("seq2_first_owner", (rv_log.size() > 0) ? rv_log[0] : 1'bx, OWNER_D);
      chk("seq2_second_owner", (rv_log.size() > 1) ? rv_log[1] : 1'bx, OWNER_I);

      // D write produces no response and no occupancy, then read it back
      base = n_drv;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      settle();
      chk("wr_d_gnt", d_gnt, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 32'h200);
      chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      settle(); chk("wr_outst_cnt", outst_cnt, 0);
      drain(4);
      chk("wr_no_d_rvalid", n_drv - base, 0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; tick();
      drain(5);
      chk("wr_readback", last_drdata, 32'hDEADBEEF);

      // fill the tag FIFO, then release one response
      hold = 1'b1; i_req = 1'b1; i_addr = 32'h80;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_igrant) i_addr = i_addr + 32'd4;
      end
      settle();
      chk("full_outst_cnt", outst_cnt, 4);
      chk("full_mem_req", mem_req, 0);
      hold = 1'b0;
      tick();
      settle();
      chk("full_pop_mem_req", mem_req, 0);
      chk("full_pop_i_rvalid", i_rvalid, 1);
      tick();
      settle();
      chk("after_pop_outst", outst_cnt, 3);
      chk("after_pop_i_gnt", i_gnt, 1);
      tick();
      drain(10);

      // both requesting continuously: grant pattern
      i_req = 1'b1; i_addr = 32'hC0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h140;
      pat = '0;
      for (int k = 0; k < 8; k++) begin
         settle();
         pat[7-k] = d_gnt;
         tick();
      end
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
      exp_pat = 8'b1110_1110;
`else
      exp_pat = 8'b1111_1111;
`endif
      chk("starve_d_gnt_pattern", pat, exp_pat);
      drain(8);

      // orphan response: dropped, err sticky until reset
      orphan_req = 1'b1;
      tick();
      settle();
      chk("orphan_i_rvalid", i_rvalid, 0);
      chk("orphan_d_rvalid", d_rvalid, 0);
      chk("orphan_err_before_edge", err, 0);
      tick();
      settle(); chk("orphan_err_set", err, 1);
      repeat (3) tick();
      settle(); chk("orphan_err_sticky", err, 1);
      rst_n = 1'b0;
      settle(); chk("orphan_err_cleared", err, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // read in flight across reset becomes an orphan
      i_req = 1'b1; i_addr = 32'h10; tick();
      i_req = 1'b0; rst_n = 1'b0;
      settle(); chk("inflight_rst_outst", outst_cnt, 0);
      tick();
      rst_n = 1'b1;
      settle(); chk("inflight_i_rvalid", i_rvalid, 0);
      tick();
      settle(); chk("inflight_err", err, 1);
      rst_n = 1'b0; tick();
      rst_n = 1'b1; drain(4);

      chk("end_expq_empty", expq.size(), 0);
      chk("end_pend_empty", pend.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester (I) and data-access requester (D).
- Arbitrates per cycle using req/gnt handshakes. Tracks outstanding reads in a tag FIFO and routes in-order read responses back to their owner.
- Sits between the pipelined core's IF/MA stages and the memory model; replaces separate IMEM/DMEM when a unified memory is used.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- MAX_OUTST, 4, maximum outstanding reads (tag FIFO depth, power of 2, ≥2)
- STARVE_LIMIT, 3, consecutive I-losses before I is forced to win (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  memory read response valid (in order, ≥1 cycle after gnt)
- mem_rdata  in  DW  memory read data
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of reads in flight
- err  out  1  sticky: mem_rvalid arrived with no read outstanding

Behaviour:
- Reset (rst_n low, asynchronous): tag FIFO emptied; outst_cnt=0; err=0; starve counter=0.
  - All handshake outputs (i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req) are forced to 0 while rst_n is low.
  - In-flight responses arriving after reset release are treated as orphans: err is set, the response is not routed.
- Winner selection (combinational): D wins if d_req; otherwise I wins if i_req.
- mem_req = (i_req | d_req) & ~full, where full = (outst_cnt == MAX_OUTST). Full blocks writes as well as reads.
  - A pop in the same cycle does not unblock a full FIFO.
- mem_we/mem_addr/mem_wdata come from the winner. For I: mem_we=0 and mem_wdata=0.
- Grant: i_gnt = mem_gnt & mem_req & winner==I; d_gnt likewise for D. The loser sees gnt=0 and must hold its request stable.
  - The requester may change address only after its gnt.
- Accepted reads push the owner tag (0=I, 1=D) into the FIFO. Accepted writes push nothing and produce no rvalid.
- On mem_rvalid with the FIFO non-empty: pop the head. Assert i_rvalid or d_rvalid for that single cycle per the tag.
  - i_rdata and d_rdata both carry mem_rdata unconditionally.
- On mem_rvalid with the FIFO empty: drop the response; set err (held until reset).
- Simultaneous push and pop (not full): FIFO head advances, tail advances, outst_cnt unchanged.
- Pointers are log2(MAX_OUTST) bits and wrap modulo MAX_OUTST. Empty/full are derived from outst_cnt.
- Zero-latency combinational response paths (mem_rvalid → x_rvalid) are allowed; no request-to-grant register stage.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STARVE_GUARD_EN.
- Defined: a saturating counter increments each cycle i_req=1, d_req=1 and a D grant occurs. It resets to 0 on any I grant, or when i_req=0.
  - When the counter ≥ STARVE_LIMIT, I wins arbitration over D.
- Undefined: strict D priority; no counter is synthesized.

Decomposition:
- Package mem_arb_pkg:
  - owner tag constants OWNER_I=1'b0, OWNER_D=1'b1
  - default AW/DW
  - function computing counter width from MAX_OUTST
- Sub-module mem_arb_tag_fifo: 1-bit-wide, MAX_OUTST-deep synchronous FIFO with push/pop/empty/full/count, async active-low reset.

Test Plan:
- I-only reads at 0x00, 0x04, 0x08; memory gnt every cycle, rvalid 2 cycles later → i_gnt on 3 consecutive cycles; i_rvalid ×3 with matching data; outst_cnt peaks at 2.
- i_req and d_req (read 0x100) in the same cycle → d_gnt=1, i_gnt=0. Next cycle i_gnt=1. Responses route D first, then I.
- D write 0x200=0xDEADBEEF → d_gnt=1, mem_we=1, no d_rvalid, outst_cnt stays 0.
- Hold mem_rvalid=0 with 4 read grants (MAX_OUTST=4) → outst_cnt=4, mem_req=0 despite i_req=1. Then one mem_rvalid → count=3, the next request is granted.
- Pulse mem_rvalid with no outstanding read → no x_rvalid; err=1 and stays 1 until rst_n low.
- With MEM_PORT_ARBITER_STARVE_GUARD_EN, STARVE_LIMIT=3, i_req and d_req held high → D,D,D,I grant pattern repeats. Without the macro → D only.
